btn_repeat: RTL

//  N-channel push-button conditioner replacing the ad-hoc press/auto-repeat logic in top.
//  Per channel it synchronises the pad, debounces it and emits one-cycle press pulses:
//  one on press, then auto-repeat pulses after an initial delay (e.g. held BTN_A -> repeated scroll).

---
 rtl/btn_repeat.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/btn_repeat.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : btn_repeat
// Purpose  : N-channel push-button conditioner. Each channel synchronises
//            the pad, debounces it, and emits press pulses: one on press,
//            then auto-repeat pulses after an initial delay. It also provides
//            a debounced level, a release pulse and a repeating indicator.
// Revision : 1.0 - initial release
// ============================================================================
module btn_repeat #(
  parameter int N_BTN        = 1,
  parameter int ACTIVE_LOW   = 1,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 120_000,
  parameter int START_DELAY  = 6_000_000,
  parameter int REPEAT_DELAY = 1_200_000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_BTN-1:0] i_btn,
  input  logic [N_BTN-1:0] i_repeat_en,
  output logic [N_BTN-1:0] o_held,
  output logic [N_BTN-1:0] o_press,
  output logic [N_BTN-1:0] o_release,
  output logic [N_BTN-1:0] o_repeating
);

  localparam int C_DW   = $clog2(DEBOUNCE_CYC + 1);
  localparam int C_RMAX = (START_DELAY > REPEAT_DELAY) ? START_DELAY : REPEAT_DELAY;
  localparam int C_RW   = $clog2(C_RMAX + 1);

  localparam logic [C_DW-1:0] C_DEB_LAST   = C_DW'(DEBOUNCE_CYC - 1);
  localparam logic [C_RW-1:0] C_START_LAST = C_RW'(START_DELAY - 1);
  localparam logic [C_RW-1:0] C_REP_LAST   = C_RW'(REPEAT_DELAY - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FIRST  = 2'd1,
    S_REPEAT = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  // Normalise polarity so that 1 always means "pressed" from here on.
  logic [N_BTN-1:0] w_pad;
  assign w_pad = (ACTIVE_LOW != 0) ? ~i_btn : i_btn;

  generate
    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q;
      logic                   w_s;
      logic [C_DW-1:0]        dcnt_q;
      logic                   stable_q;
      state_t                 state_q, state_d;
      logic [C_RW-1:0]        rcnt_q, rcnt_d;
      logic                   held_q;
      logic                   press_q, press_d;
      logic                   release_q, release_d;
      logic                   repeating_q;
      logic                   w_rise, w_fall;

      assign w_s = sync_q[SYNC_STAGES-1];

      // Shift the asynchronous pad through the synchroniser chain.
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          sync_q <= '0;
        end else begin
          sync_q <= {sync_q[SYNC_STAGES-2:0], w_pad[g]};
        end
      end

      // Accept a new level only after it has differed for DEBOUNCE_CYC cycles.
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          dcnt_q   <= '0;
          stable_q <= 1'b0;
        end else if (w_s == stable_q) begin
          dcnt_q <= '0;
        end else if (dcnt_q == C_DEB_LAST) begin
          stable_q <= w_s;
          dcnt_q   <= '0;
        end else begin
          dcnt_q <= dcnt_q + C_DW'(1);
        end
      end

      // held_q lags stable_q by one cycle, so comparing them gives the edges.
      assign w_rise = stable_q & ~held_q;
      assign w_fall = ~stable_q & held_q;

      // Next-state and pulse logic; a release always beats a due repeat.
      always_comb begin
        state_d   = state_q;
        rcnt_d    = rcnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (w_fall) begin
          release_d = 1'b1;
          state_d   = S_IDLE;
          rcnt_d    = '0;
        end else begin
          case (state_q)
            S_IDLE: begin
              if (w_rise) begin
                press_d = 1'b1;
                rcnt_d  = '0;
                state_d = i_repeat_en[g] ? S_FIRST : S_HOLD;
              end
            end
            S_FIRST: begin
              if (!i_repeat_en[g]) begin
                state_d = S_HOLD;
                rcnt_d  = '0;
              end else if (rcnt_q == C_START_LAST) begin
                press_d = 1'b1;
                rcnt_d  = '0;
                state_d = S_REPEAT;
              end else begin
                rcnt_d = rcnt_q + C_RW'(1);
              end
            end
            S_REPEAT: begin
              if (!i_repeat_en[g]) begin
                state_d = S_HOLD;
                rcnt_d  = '0;
              end else if (rcnt_q == C_REP_LAST) begin
                press_d = 1'b1;
                rcnt_d  = '0;
              end else begin
                rcnt_d = rcnt_q + C_RW'(1);
              end
            end
            S_HOLD: begin
              rcnt_d = '0;
            end
            default: begin
              state_d = S_IDLE;
              rcnt_d  = '0;
            end
          endcase
        end
      end

      // State, counter and registered outputs; reset aborts anything pending.
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          state_q     <= S_IDLE;
          rcnt_q      <= '0;
          held_q      <= 1'b0;
          press_q     <= 1'b0;
          release_q   <= 1'b0;
          repeating_q <= 1'b0;
        end else begin
          state_q     <= state_d;
          rcnt_q      <= rcnt_d;
          held_q      <= stable_q;
          press_q     <= press_d;
          release_q   <= release_d;
          repeating_q <= (state_q == S_REPEAT);
        end
      end

      assign o_held[g]      = held_q;
      assign o_press[g]     = press_q;
      assign o_release[g]   = release_q;
      assign o_repeating[g] = repeating_q;
    end
  endgenerate

endmodule
`default_nettype wire
